regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources: the ALU result path and the load-return path.
- Load returns are buffered in a small FIFO. ALU results have priority, and a starvation counter bounds how long loads can wait.
- Reports read-after-write hazards against queued loads so the issue stage can stall.
- Sits between the execute/memory stages and the register file write port (iAddrWrite/iDataWrite/iEnWrite).

Parameters:
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register address width
- LD_FIFO_DEPTH, 4, load-return FIFO entries (power of 2, >=2)
- STARVE_LIMIT, 3, consecutive ALU grants allowed while a load waits (>=1)

Ports:
- iClk  in  1  single clock; all state updates on posedge
- iRst_n  in  1  asynchronous active-low reset
- iAluValid  in  1  ALU writeback request
- oAluReady  out  1  ALU request accepted this cycle
- iAluAddr  in  ADDR_WIDTH  ALU destination register
- iAluData  in  DATA_WIDTH  ALU result
- iLdValid  in  1  load-return valid
- oLdReady  out  1  load FIFO can accept
- iLdAddr  in  ADDR_WIDTH  load destination register
- iLdData  in  DATA_WIDTH  load data
- iAddrRead0  in  ADDR_WIDTH  hazard lookup address, port 0
- iAddrRead1  in  ADDR_WIDTH  hazard lookup address, port 1
- oHazard0  out  1  queued load targets iAddrRead0
- oHazard1  out  1  queued load targets iAddrRead1
- oEnWrite  out  1  register file write enable
- oAddrWrite  out  ADDR_WIDTH  register file write address
- oDataWrite  out  DATA_WIDTH  register file write data
- oLdCount  out  $clog2(LD_FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async assert, sync release):
  - FIFO pointers, oLdCount and the starve counter go to 0.
  - oEnWrite, oAddrWrite and oDataWrite go to 0.
  - Queued loads are discarded; a reset mid-operation loses them by design.
- Load FIFO:
  - oLdReady = (oLdCount != LD_FIFO_DEPTH). It is combinational and does not depend on a same-cycle pop, so a full FIFO refuses a push even when popping.
  - Push when iLdValid && oLdReady. Push and pop in the same cycle leaves oLdCount unchanged.
  - No fall-through: an entry pushed at edge N is poppable from cycle N+1.
  - Pointers wrap modulo LD_FIFO_DEPTH.
- Arbitration is combinational each cycle, with at most one grant.
  - force = (starve_cnt >= STARVE_LIMIT) && FIFO non-empty.
  - force: grant LOAD (pop head); oAluReady = 0.
  - else iAluValid: grant ALU; oAluReady = 1.
  - else FIFO non-empty: grant LOAD.
  - else: no grant.
  - oAluReady = !force. It is independent of iAluValid, and iAluValid must not depend on oAluReady.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on an ALU grant while the FIFO is non-empty.
  - Clears on a LOAD grant or when the FIFO is empty.
  - Worst-case load wait is STARVE_LIMIT+1 cycles after reaching the FIFO head.
- Write output is registered one cycle after the grant.
  - oEnWrite = granted && (addr != 0). oAddrWrite/oDataWrite take the granted source's values.
  - With no grant, oEnWrite = 0 and the address/data outputs hold their previous values.
  - A write to register 0 is accepted (handshake completes, FIFO pops) but oEnWrite stays 0.
- Latency:
  - ALU: accept at edge N, oEnWrite high in cycle N+1.
  - Load into an empty FIFO with no ALU traffic: push at edge N, pop at edge N+1, oEnWrite high in cycle N+2.
- Hazard:
  - oHazardK = OR over valid FIFO entries of (entry.addr == iAddrReadK), gated by iAddrReadK != 0. Combinational.
  - The registered output stage is excluded from the check.
  - A same-cycle incoming push is excluded from the check.
- Ordering:
  - Loads are written in FIFO order.
  - ALU/load writes to the same register follow grant order; the upstream stage prevents this using oHazard.

Decomposition:
- Package regfile_wb_pkg: grant encoding constants GNT_NONE=2'd0, GNT_ALU=2'd1, GNT_LD=2'd2; a struct/typedef for the {addr,data} writeback entry.
- Sub-module wb_sync_fifo:
  - Parameterised depth and width; push/pop, count, full/empty.
  - Exposes all entry addresses plus a valid mask for the hazard compare.
- Arbiter, starve counter and output register stay in regfile_wb_arbiter.

Test Plan:
- Reset mid-traffic: 3 loads queued, pulse iRst_n low -> oLdCount=0, oEnWrite=0 immediately (async); after release no queued write ever appears.
- ALU only: iAluValid every cycle, addr 5..8, data 0xA5A5_0005.. -> oEnWrite each following cycle with matching addr/data; oAluReady constantly 1.
- Load only: single load addr 3, data 0x1234_5678 pushed at edge N -> oEnWrite=1, oAddrWrite=3, oDataWrite=0x1234_5678 in cycle N+2.
- Starvation: 1 load queued with continuous ALU traffic, STARVE_LIMIT=3 -> 3 ALU writes, then oAluReady=0 for one cycle and the load is written, then ALU resumes.
- Full FIFO: push 4 loads with ALU saturating -> oLdReady=0 at count 4, including in the cycle the forced pop occurs; a 5th valid load is held until oLdReady=1.
- Hazard and register 0:
  - Queue a load to addr 7, set iAddrRead0=7 and iAddrRead1=0 -> oHazard0=1, oHazard1=0; oHazard0 clears after the pop.
  - ALU write to addr 0 -> handshake completes, oEnWrite stays 0.

Source files
------------

// File: rtl/regfile_wb_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   - Grant encoding used by the arbiter to select the write-port source.
//   - Default widths and the {addr,data} writeback entry layout for the
//     default configuration.
package regfile_wb_pkg;

    typedef logic [1:0] gnt_t;

    localparam gnt_t GNT_NONE = 2'd0;
    localparam gnt_t GNT_ALU  = 2'd1;
    localparam gnt_t GNT_LD   = 2'd2;

    localparam int unsigned WB_ADDR_W = 5;
    localparam int unsigned WB_DATA_W = 32;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_sync_fifo.sv
// Small synchronous FIFO for buffered load returns.
//   clk_i / rst_ni      : clock, asynchronous active-low reset
//   push_i / wdata_i    : write request and entry (ignored when full)
//   pop_i / rdata_o     : read request and head entry (ignored when empty)
//   count_o             : occupancy, 0..DEPTH
//   full_o / empty_o    : occupancy flags
//   entries_o / valid_o : raw storage and per-slot valid mask for lookups
// No fall-through: an entry written at an edge is visible from the next cycle.
module wb_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 37,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic [CNT_W-1:0]             count_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [DEPTH-1:0][WIDTH-1:0]  entries_o,
    output logic [DEPTH-1:0]             valid_o
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic                        do_push, do_pop;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;
    assign count_o   = count_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign entries_o = mem_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointer overflow is the modulo wrap.
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Slot i holds a live entry when its distance from the head is below count.
    always_comb begin
        valid_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_o[i] = {1'b0, PTR_W'(PTR_W'(i) - rd_ptr_q)} < count_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: every read path is qualified by the valid mask.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter between the ALU result path and buffered
// load returns.
//   iClk / iRst_n                 : clock, asynchronous active-low reset
//   iAluValid/oAluReady/Addr/Data : ALU writeback handshake (priority source)
//   iLdValid/oLdReady/Addr/Data   : load-return handshake into the FIFO
//   iAddrRead0/1, oHazard0/1      : RAW lookup against queued loads
//   oEnWrite/oAddrWrite/oDataWrite: registered register-file write port
//   oLdCount                      : load FIFO occupancy
// ALU wins by default; after STARVE_LIMIT consecutive ALU grants while a load
// waits, the head load is forced through and the ALU is held off for a cycle.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = WB_DATA_W,
    parameter int unsigned ADDR_WIDTH    = WB_ADDR_W,
    parameter int unsigned LD_FIFO_DEPTH = 4,
    parameter int unsigned STARVE_LIMIT  = 3,
    localparam int unsigned CNT_W        = $clog2(LD_FIFO_DEPTH) + 1
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic                  iAluValid,
    output logic                  oAluReady,
    input  logic [ADDR_WIDTH-1:0] iAluAddr,
    input  logic [DATA_WIDTH-1:0] iAluData,
    input  logic                  iLdValid,
    output logic                  oLdReady,
    input  logic [ADDR_WIDTH-1:0] iLdAddr,
    input  logic [DATA_WIDTH-1:0] iLdData,
    input  logic [ADDR_WIDTH-1:0] iAddrRead0,
    input  logic [ADDR_WIDTH-1:0] iAddrRead1,
    output logic                  oHazard0,
    output logic                  oHazard1,
    output logic                  oEnWrite,
    output logic [ADDR_WIDTH-1:0] oAddrWrite,
    output logic [DATA_WIDTH-1:0] oDataWrite,
    output logic [CNT_W-1:0]      oLdCount
);

    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned ENT_W = ADDR_WIDTH + DATA_WIDTH;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    // Load FIFO
    entry_t                          ld_in;
    entry_t                          ld_head;
    logic [ENT_W-1:0]                fifo_rdata;
    logic [LD_FIFO_DEPTH-1:0][ENT_W-1:0] fifo_entries;
    logic [LD_FIFO_DEPTH-1:0]        fifo_valid;
    logic                            fifo_full, fifo_empty;
    logic                            ld_push, ld_pop;

    // Arbitration
    gnt_t                  gnt;
    logic                  force_ld;
    logic [STV_W-1:0]      starve_q, starve_d;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    // Registered write port
    logic                  en_q, en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // Hazard lookup
    entry_t                hz_entry;
    logic                  hz0, hz1;

    assign ld_in.addr = iLdAddr;
    assign ld_in.data = iLdData;
    assign ld_head    = entry_t'(fifo_rdata);

    // Ready depends only on occupancy: a full FIFO refuses even while popping.
    assign oLdReady = !fifo_full;
    assign ld_push  = iLdValid && oLdReady;
    assign ld_pop   = (gnt == GNT_LD);

    wb_sync_fifo #(
        .DEPTH (LD_FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_ld_fifo (
        .clk_i     (iClk),
        .rst_ni    (iRst_n),
        .push_i    (ld_push),
        .wdata_i   (ld_in),
        .pop_i     (ld_pop),
        .rdata_o   (fifo_rdata),
        .count_o   (oLdCount),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .entries_o (fifo_entries),
        .valid_o   (fifo_valid)
    );

    always_comb begin
        force_ld = (starve_q >= STV_W'(STARVE_LIMIT)) && !fifo_empty;
        gnt      = GNT_NONE;
        if (force_ld) begin
            gnt = GNT_LD;
        end else if (iAluValid) begin
            gnt = GNT_ALU;
        end else if (!fifo_empty) begin
            gnt = GNT_LD;
        end
    end

    // Ready must not look at iAluValid so upstream can present valid freely.
    assign oAluReady = !force_ld;

    always_comb begin
        sel_addr = iAluAddr;
        sel_data = iAluData;
        if (gnt == GNT_LD) begin
            sel_addr = ld_head.addr;
            sel_data = ld_head.data;
        end
    end

    // Counts ALU grants that bypassed a waiting load; saturates at the limit.
    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || (gnt == GNT_LD)) begin
            starve_d = '0;
        end else if ((gnt == GNT_ALU) && (starve_q < STV_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + STV_W'(1);
        end
    end

    // Register 0 is architecturally zero: handshake completes, no write.
    always_comb begin
        en_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        if (gnt != GNT_NONE) begin
            en_d   = (sel_addr != '0);
            addr_d = sel_addr;
            data_d = sel_data;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            starve_q <= '0;
            en_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            starve_q <= starve_d;
            en_q     <= en_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    assign oEnWrite   = en_q;
    assign oAddrWrite = addr_q;
    assign oDataWrite = data_q;

    // Only queued entries count; the output stage and a same-cycle push do not.
    always_comb begin
        hz0      = 1'b0;
        hz1      = 1'b0;
        hz_entry = '0;
        for (int i = 0; i < LD_FIFO_DEPTH; i++) begin
            hz_entry = entry_t'(fifo_entries[i]);
            if (fifo_valid[i] && (hz_entry.addr == iAddrRead0)) begin
                hz0 = 1'b1;
            end
            if (fifo_valid[i] && (hz_entry.addr == iAddrRead1)) begin
                hz1 = 1'b1;
            end
        end
    end

    assign oHazard0 = hz0 && (iAddrRead0 != '0);
    assign oHazard1 = hz1 && (iAddrRead1 != '0);

endmodule
